// File: rtl/dualport_bram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port block RAM.
// The optional output register stage is enabled by defining DUALPORT_BRAM_OUTREG_EN.
package dualport_bram_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAX_DW    = 1024;
  localparam int MAX_LANES = MAX_DW / 8;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0]    old_word,
    input logic [MAX_DW-1:0]    new_word,
    input logic [MAX_LANES-1:0] be
  );
    logic [MAX_DW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dualport_bram_port.sv
// One access port: request qualification, read-data selection and output pipeline.
// Defining DUALPORT_BRAM_OUTREG_EN adds a second output register stage.
module dualport_bram_port
  import dualport_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WRITE_MODE = READ_FIRST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    cs,
  input  logic                    we,
  input  logic                    oe,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH-1:0]   mem_word,
  output logic                    access,
  output logic                    write,
  output logic [DATA_WIDTH/8-1:0] write_lanes,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    valid
);

  logic                  read;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] read_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign read        = enable & cs & oe;
  assign write       = enable & cs & we;
  assign access      = read | write;
  assign write_lanes = write ? be : '0;

  // mem_word is the pre-write content, so cross-port writes never leak in here.
  assign merged    = DATA_WIDTH'(byte_merge(MAX_DW'(mem_word), MAX_DW'(din), MAX_LANES'(be)));
  assign read_word = (WRITE_MODE == WRITE_FIRST && write) ? merged : mem_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= read;
      if (read) s1_data <= read_word;
    end
  end

`ifdef DUALPORT_BRAM_OUTREG_EN
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_data;
    end
  end

  assign dout  = s2_data;
  assign valid = s2_valid;
`else
  assign dout  = s1_data;
  assign valid = s1_valid;
`endif

endmodule

// File: rtl/dualport_bram_be.sv
// True dual-port byte-enabled RAM with post-reset clear sweep and collision flag.
// Defining DUALPORT_BRAM_OUTREG_EN adds one output stage (dout, valid, collision).
module dualport_bram_be
  import dualport_bram_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 8,
  parameter int                    WRITE_MODE    = READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  output logic                     collision,
  input  logic                     cs_0,
  input  logic                     cs_1,
  input  logic                     we_0,
  input  logic                     we_1,
  input  logic                     oe_0,
  input  logic                     oe_1,
  input  logic [DATA_WIDTH/8-1:0]  be_0,
  input  logic [DATA_WIDTH/8-1:0]  be_1,
  input  logic [ADDRESS_WIDTH-1:0] address_0,
  input  logic [ADDRESS_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0]    din_0,
  input  logic [DATA_WIDTH-1:0]    din_1,
  output logic [DATA_WIDTH-1:0]    dout_0,
  output logic [DATA_WIDTH-1:0]    dout_1,
  output logic                     valid_0,
  output logic                     valid_1
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int NB    = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] sweep_addr;

  logic          access_0, access_1;
  logic          write_0, write_1;
  logic [NB-1:0] lanes_0, lanes_1;
  logic          collision_now;
  logic          collision_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      sweep_addr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep_addr <= sweep_addr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && (&sweep_addr)) state_next = READY;
  end

  assign ready = (state == READY);

  dualport_bram_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_MODE (WRITE_MODE)
  ) u_port_0 (
    .clk         (clk),
    .rst         (rst),
    .enable      (ready),
    .cs          (cs_0),
    .we          (we_0),
    .oe          (oe_0),
    .be          (be_0),
    .din         (din_0),
    .mem_word    (mem[address_0]),
    .access      (access_0),
    .write       (write_0),
    .write_lanes (lanes_0),
    .dout        (dout_0),
    .valid       (valid_0)
  );

  dualport_bram_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_MODE (WRITE_MODE)
  ) u_port_1 (
    .clk         (clk),
    .rst         (rst),
    .enable      (ready),
    .cs          (cs_1),
    .we          (we_1),
    .oe          (oe_1),
    .be          (be_1),
    .din         (din_1),
    .mem_word    (mem[address_1]),
    .access      (access_1),
    .write       (write_1),
    .write_lanes (lanes_1),
    .dout        (dout_1),
    .valid       (valid_1)
  );

  // Port 0 lanes are assigned last so they win on a same-address double write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[sweep_addr] <= INIT_VALUE;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (lanes_1[i]) mem[address_1][i*8 +: 8] <= din_1[i*8 +: 8];
        end
        for (int i = 0; i < NB; i++) begin
          if (lanes_0[i]) mem[address_0][i*8 +: 8] <= din_0[i*8 +: 8];
        end
      end
    end
  end

  assign collision_now = access_0 & access_1 & (address_0 == address_1) & (write_0 | write_1);

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= collision_now;
  end

`ifdef DUALPORT_BRAM_OUTREG_EN
  logic collision_q2;

  always_ff @(posedge clk) begin
    if (rst) collision_q2 <= 1'b0;
    else     collision_q2 <= collision_q;
  end

  assign collision = collision_q2;
`else
  assign collision = collision_q;
`endif

endmodule

// File: doc/dualport_bram_be.md
Name: dualport_bram_be

Overview:
- True dual-port synchronous block RAM, single clock, depth 2**ADDRESS_WIDTH words of DATA_WIDTH bits.
- Both ports read/write the same storage array; adds per-byte write enables, selectable same-port read-during-write mode, cross-port collision arbitration/flag, per-port read-valid, and a post-reset memory-clear sequencer.
- Shared buffer between two engines in the datapath; replaces the unparametrised dual-port RAM.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDRESS_WIDTH, 8, address bits; DEPTH = 2**ADDRESS_WIDTH.
- WRITE_MODE, 0, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new merged data).
- INIT_VALUE, 0, word written to every location by the clear sequencer.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ready  out  1  high when the clear sweep is done and accesses are accepted.
- collision  out  1  one-cycle pulse: same-address cross-port access with at least one write.
- cs_0 / cs_1  in  1  port chip select.
- we_0 / we_1  in  1  write enable (qualified by cs).
- oe_0 / oe_1  in  1  read enable (qualified by cs).
- be_0 / be_1  in  DATA_WIDTH/8  byte-lane write enables.
- address_0 / address_1  in  ADDRESS_WIDTH  word address.
- din_0 / din_1  in  DATA_WIDTH  write data.
- dout_0 / dout_1  out  DATA_WIDTH  registered read data.
- valid_0 / valid_1  out  1  dout carries the result of a read issued LAT cycles earlier.

Behaviour:
- Reset: ready=0, collision=0, dout_*=0, valid_*=0, FSM=INIT, sweep address=0. Memory contents are not reset directly; the sweep clears them.
- FSM INIT: each cycle writes INIT_VALUE to sweep address, then increments it. At DEPTH-1, go to READY next cycle. Sweep takes exactly DEPTH cycles; ready rises on cycle DEPTH after rst falls.
- In INIT, port requests are ignored: no writes, valid stays 0.
- FSM READY: ready=1; stays until rst.
- rst asserted in any state: next cycle is the reset state. Sweep restarts from 0, in-flight reads are dropped (valid=0).
- Write (READY, cs&we): byte lane i of mem[address] <= din lane i where be[i]=1. be=0 writes nothing.
- Read (READY, cs&oe): LAT=1. dout/valid update on the next edge. valid=1 for one cycle per read.
- No read: dout holds its last value and valid=0.
- cs&we&oe on one port: READ_FIRST returns the pre-write word; WRITE_FIRST returns the byte-merged new word.
- Cross-port, same address, both writing: port 0 wins on lanes where be_0=1; port 1 lanes apply only where be_0=0. collision=1.
- Cross-port, one writes and the other reads the same address: the reader gets the pre-write word regardless of WRITE_MODE. collision=1.
- Both ports reading the same address: no collision, both get data.
- collision is registered and aligned with the read-data cycle (request+1).
- Address wraps naturally; there are no out-of-range accesses.

Optional Feature:
- DUALPORT_BRAM_OUTREG_EN defined: extra output register stage. LAT=2 for dout, valid and collision. Held-value and valid rules are unchanged at the new stage.
- Undefined: LAT=1 as above.

Decomposition:
- Package dualport_bram_pkg holds:
  - WRITE_MODE constants READ_FIRST=0, WRITE_FIRST=1.
  - FSM state typedef {INIT, READY}.
  - Function computing byte-lane count and the byte-merge helper.
- One sub-module, dualport_bram_port, instantiated twice: request qualification, byte merge, read-data selection per WRITE_MODE, output/valid pipeline including the optional stage.
- Top level owns the storage array, cross-port arbitration, collision logic and the clear FSM.

Test Plan:
- Reset, then read all words: ready rises exactly 256 cycles after rst falls (ADDRESS_WIDTH=8). All reads return 0x00000000 with valid one cycle after the request.
- Port 0 writes 0xAABBCCDD to addr 0x10 with be=4'b0101, after the location was cleared: read returns 0x00BB00DD.
- Same-port cs&we&oe at addr 0x20 holding 0x11111111, din=0x22222222, be=4'hF: WRITE_MODE=0 returns 0x11111111, WRITE_MODE=1 returns 0x22222222. A subsequent read returns 0x22222222.
- Both ports write addr 0x30 in the same cycle: port 0 din=0x12345678 be=4'b0011, port 1 din=0xCAFEF00D be=4'hF. Memory ends as 0xCAFE5678 and collision pulses one cycle.
- Port 0 writes 0x55 to addr 0x40 (old value 0x0) while port 1 reads addr 0x40: dout_1=0x0, valid_1=1, collision=1. The next read gives 0x55.
- rst pulsed mid-sweep at sweep address 100, with a read in flight after ready: valid never asserts for the dropped read. The sweep restarts, ready returns 256 cycles after rst falls, and all locations read INIT_VALUE.
- Repeat the read tests with DUALPORT_BRAM_OUTREG_EN defined: latency is 2 cycles.
